mem_bus_if: RTL and testbench

Memory bus interface between the CPU control FSM and the external ROM/RAM devices. It samples the control block's memory request (`mem_cs`, `mem_oe`, `mem_we`) together with the CPU address and write data, then runs a multi-cycle external access with per-region wait states. It returns read data and a `mem_rdy` completion flag that the control FSM uses to advance its fetch and load states.

---
 rtl/mem_bus_if.sv | 126 ++++++++++++
 tb/tb_mem_bus_if.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// Memory bus interface: turns a control-FSM memory request into a multi-cycle external
// ROM/RAM access with per-region wait states, returning read data and a completion flag.
module mem_bus_if #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0,
  parameter logic [15:0] RAM_BASE = 16'hC000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_cs,
  input  logic        mem_oe,
  input  logic        mem_we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        data_oe,
  output logic        mem_rdy,
  output logic        err,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dout,
  input  logic [7:0]  ext_din,
  output logic        ext_rom_ce_n,
  output logic        ext_ram_ce_n,
  output logic        ext_oe_n,
  output logic        ext_we_n
);

  localparam logic [3:0] RomWait = 4'(ROM_WAIT);
  localparam logic [3:0] RamWait = 4'(RAM_WAIT);

  typedef enum logic [2:0] {StIdle, StAddr, StWait, StData, StHold} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       is_wr_q;

  logic addr_ram;
  logic req_both;
  logic req_one;
  logic req_any;

  assign addr_ram = (addr >= RAM_BASE);
  assign req_both = mem_cs & mem_oe & mem_we;
  assign req_one  = mem_cs & (mem_oe ^ mem_we);
  assign req_any  = mem_cs & (mem_oe | mem_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      is_wr_q      <= 1'b0;
      ext_addr     <= 16'd0;
      ext_dout     <= 8'd0;
      rdata        <= 8'd0;
      data_oe      <= 1'b0;
      mem_rdy      <= 1'b0;
      err          <= 1'b0;
      ext_rom_ce_n <= 1'b1;
      ext_ram_ce_n <= 1'b1;
      ext_oe_n     <= 1'b1;
      ext_we_n     <= 1'b1;
    end else begin
      err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_both) begin
            err <= 1'b1;
          end else if (req_one) begin
            if (mem_we && !addr_ram) begin
              // ROM write: flag it but complete at once so control never stalls.
              err     <= 1'b1;
              mem_rdy <= 1'b1;
              data_oe <= 1'b0;
              state_q <= StHold;
            end else begin
              ext_addr     <= addr;
              ext_dout     <= wdata;
              is_wr_q      <= mem_we;
              cnt_q        <= addr_ram ? RamWait : RomWait;
              ext_rom_ce_n <= addr_ram;
              ext_ram_ce_n <= ~addr_ram;
              ext_oe_n     <= mem_we;
              ext_we_n     <= ~mem_we;
              state_q      <= StAddr;
            end
          end
        end
        StAddr: begin
          if (cnt_q == 4'd0) begin
            state_q <= StData;
            if (is_wr_q) ext_we_n <= 1'b1;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StData;
            // Release write strobe one cycle early so address/data stay held past it.
            if (is_wr_q) ext_we_n <= 1'b1;
          end
        end
        StData: begin
          ext_rom_ce_n <= 1'b1;
          ext_ram_ce_n <= 1'b1;
          ext_oe_n     <= 1'b1;
          ext_we_n     <= 1'b1;
          mem_rdy      <= 1'b1;
          data_oe      <= ~is_wr_q;
          if (!is_wr_q) rdata <= ext_din;
          state_q <= StHold;
        end
        StHold: begin
          if (!req_any) begin
            mem_rdy <= 1'b0;
            data_oe <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Randomized bench for mem_bus_if: two instances with different wait settings are compared
// cycle by cycle against a timeline model derived from the access latency rules.
module tb_mem_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_cs, mem_oe, mem_we;
  logic [15:0] addr;
  logic [7:0]  wdata, ext_din;

  logic [1:0][7:0]  rdata, ext_dout;
  logic [1:0][15:0] ext_addr;
  logic [1:0]       data_oe, mem_rdy, err, rom_ce_n, ram_ce_n, oe_n, we_n;

  logic [15:0] m_addr  [2];
  logic [7:0]  m_dout  [2];
  logic [7:0]  m_rdata [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_bus_if #(.ROM_WAIT(1), .RAM_WAIT(0), .RAM_BASE(16'hC000)) u_dut0 (
    .clk(clk), .rst(rst), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .addr(addr), .wdata(wdata), .rdata(rdata[0]), .data_oe(data_oe[0]),
    .mem_rdy(mem_rdy[0]), .err(err[0]), .ext_addr(ext_addr[0]), .ext_dout(ext_dout[0]),
    .ext_din(ext_din), .ext_rom_ce_n(rom_ce_n[0]), .ext_ram_ce_n(ram_ce_n[0]),
    .ext_oe_n(oe_n[0]), .ext_we_n(we_n[0])
  );

  mem_bus_if #(.ROM_WAIT(3), .RAM_WAIT(2), .RAM_BASE(16'hC000)) u_dut1 (
    .clk(clk), .rst(rst), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .addr(addr), .wdata(wdata), .rdata(rdata[1]), .data_oe(data_oe[1]),
    .mem_rdy(mem_rdy[1]), .err(err[1]), .ext_addr(ext_addr[1]), .ext_dout(ext_dout[1]),
    .ext_din(ext_din), .ext_rom_ce_n(rom_ce_n[1]), .ext_ram_ce_n(ram_ce_n[1]),
    .ext_oe_n(oe_n[1]), .ext_we_n(we_n[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int wait_of(input int i, input bit ram);
    if (i == 0) return ram ? 0 : 1;
    return ram ? 2 : 3;
  endfunction

  function automatic logic [6:0] flags_of(input int i);
    return {rom_ce_n[i], ram_ce_n[i], oe_n[i], we_n[i], mem_rdy[i], data_oe[i], err[i]};
  endfunction

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s i%0d flags", tag, i), 32'(flags_of(i)), 32'h78);
      check($sformatf("%s i%0d data", tag, i), {ext_addr[i], ext_dout[i], rdata[i]}, 32'h0);
      m_addr[i]  = 16'h0;
      m_dout[i]  = 8'h0;
      m_rdata[i] = 8'h0;
    end
  endtask

  // op: 0 read, 1 write, 2 oe&we. hold < 0 drops the request right after edge 0.
  // rst_j >= 0 asserts reset asynchronously after sampling at that index.
  task automatic access(input int op, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] din, input int hold, input int rst_j);
    bit   ram, romwr, legal, active, rdy;
    int   done [2];
    int   rel, last, maxdone;
    logic [6:0] exp;
    ram    = (a >= 16'hC000);
    romwr  = (op == 1) && !ram;
    legal  = (op != 2) && !romwr;
    maxdone = 0;
    for (int i = 0; i < 2; i++) begin
      done[i] = romwr ? 0 : wait_of(i, ram) + 2;
      if (done[i] > maxdone) maxdone = done[i];
    end
    if (op == 2) begin
      rel  = 0;
      last = 1;
    end else begin
      rel  = (hold < 0) ? 0 : maxdone + hold;
      last = ((maxdone > rel) ? maxdone : rel) + 1;
    end
    mem_cs  = 1'b1;
    mem_oe  = (op != 1);
    mem_we  = (op != 0);
    addr    = a;
    wdata   = wd;
    ext_din = din;
    if (legal) begin
      for (int i = 0; i < 2; i++) begin
        m_addr[i] = a;
        m_dout[i] = wd;
      end
    end
    for (int j = 0; j <= last; j++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (op == 2) begin
          exp = {4'b1111, 2'b00, (j == 0)};
        end else begin
          active = legal && (j <= done[i] - 1);
          rdy    = (j >= done[i]) && (j <= ((done[i] > rel) ? done[i] : rel));
          exp = {!(active && !ram), !(active && ram), !(active && op == 0),
                 !(legal && op == 1 && j <= done[i] - 2), rdy, rdy && (op == 0),
                 romwr && (j == 0)};
          if (legal && op == 0 && j == done[i]) m_rdata[i] = din;
        end
        check($sformatf("a%h op%0d i%0d j%0d flags", a, op, i, j), 32'(flags_of(i)), 32'(exp));
        check($sformatf("a%h op%0d i%0d j%0d data", a, op, i, j),
              {ext_addr[i], ext_dout[i], rdata[i]}, {m_addr[i], m_dout[i], m_rdata[i]});
      end
      if (j == rst_j) begin
        #2 rst = 1'b1;
        #1 check_reset("rst_now");
        mem_cs = 1'b0;
        mem_oe = 1'b0;
        mem_we = 1'b0;
        @(negedge clk);
        check_reset("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_rel");
        return;
      end
      if (j == rel) begin
        mem_cs = 1'b0;
        mem_oe = 1'b0;
        mem_we = 1'b0;
      end
    end
  endtask

  initial begin
    int op, hold;
    logic [15:0] a;
    rst    = 1'b1;
    mem_cs = 1'b0;
    mem_oe = 1'b0;
    mem_we = 1'b0;
    addr   = 16'h0;
    wdata  = 8'h0;
    ext_din = 8'h0;
    #12 check_reset("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("por_rel");

    access(0, 16'h0150, 8'h00, 8'h3E, 2, -1);
    access(1, 16'hC000, 8'hA5, 8'h00, 1, -1);
    access(1, 16'h2000, 8'h77, 8'h00, 1, -1);
    access(2, 16'h1234, 8'h00, 8'h00, 0, -1);
    access(0, 16'hC010, 8'h00, 8'h5A, 1, -1);
    access(0, 16'h0150, 8'h00, 8'h99, 1, 2);
    access(0, 16'h0150, 8'h00, 8'hC3, 0, -1);
    access(1, 16'hFFFF, 8'h3C, 8'h00, -1, -1);
    access(0, 16'hBFFF, 8'h00, 8'h81, -1, -1);

    for (int k = 0; k < 60; k++) begin
      op   = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      a    = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[15:14] = 2'b11;
      hold = int'($urandom_range(0, 4)) - 1;
      access(op, a, 8'($urandom), 8'($urandom), hold, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
